sram_like_arbiter: RTL and testbench

Parametrised N-to-1 arbiter for the core's sram-like memory interface (req / addr_ok / data_ok handshake). It merges the fetch, load/store and future cache-refill request channels onto one sram-like slave port. Responses are routed back in order using an outstanding-transaction FIFO. It is the next generation of the single-channel fetch handshake and sits between the pipeline/cache masters and the downstream bus bridge.

---
 rtl/sram_like_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// N-to-1 arbiter for the sram-like memory interface (req / addr_ok / data_ok).
// Merges the master channels onto one slave port. A channel-id FIFO records
// the order of accepted requests so that in-order slave responses can be
// routed back to the channel that issued them.
module sram_like_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            m_req,
    input  logic [NUM_CH-1:0]            m_wr,
    input  logic [2*NUM_CH-1:0]          m_size,
    input  logic [32*NUM_CH-1:0]         m_addr,
    input  logic [4*NUM_CH-1:0]          m_wstrb,
    input  logic [32*NUM_CH-1:0]         m_wdata,
    output logic [NUM_CH-1:0]            m_addr_ok,
    output logic [NUM_CH-1:0]            m_data_ok,
    output logic [31:0]                  m_rdata,
    output logic                         s_req,
    output logic                         s_wr,
    output logic [1:0]                   s_size,
    output logic [31:0]                  s_addr,
    output logic [3:0]                   s_wstrb,
    output logic [31:0]                  s_wdata,
    input  logic                         s_addr_ok,
    input  logic                         s_data_ok,
    input  logic [31:0]                  s_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         resp_err
);

    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_req_t;

    sram_req_t [NUM_CH-1:0] ch_req;
    sram_req_t              sel;

    logic          lock_valid;
    logic [CW-1:0] lock_ch;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] base;
    logic [CW-1:0] winner;
    logic [CW-1:0] grant;
    logic [CW:0]   sum;
    logic [CW-1:0] cand;
    logic          found;

    logic [CW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic [CW-1:0] head;

    logic full;
    logic accept;
    logic pop;

    // Pack each channel's request fields so the slave mux is a single select.
    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_req[i] = {m_wr[i], m_size[2*i +: 2], m_addr[32*i +: 32],
                            m_wstrb[4*i +: 4], m_wdata[32*i +: 32]};
    end

    // Fixed priority is just round-robin with the search always starting at 0.
    assign base = (RR_MODE != 0) ? rr_ptr : '0;

    // Search for the first requester starting at base, wrapping mod NUM_CH.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, base} + (CW+1)'(k);
            if (sum >= (CW+1)'(NUM_CH))
                sum = sum - (CW+1)'(NUM_CH);
            cand = sum[CW-1:0];
            if (!found && m_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A stalled request keeps the slave until accepted, so its fields stay stable.
    assign grant  = lock_valid ? lock_ch : winner;
    assign full   = (count == OW'(DEPTH));
    assign s_req  = (lock_valid | (|m_req)) & ~full;
    assign accept = s_req & s_addr_ok;
    assign pop    = s_data_ok & (count != '0);
    assign head   = fifo_mem[rd_ptr];

    assign sel     = ch_req[grant];
    assign s_wr    = sel.wr;
    assign s_size  = sel.size;
    assign s_addr  = sel.addr;
    assign s_wstrb = sel.wstrb;
    assign s_wdata = sel.wdata;

    assign m_rdata     = s_rdata;
    assign outstanding = count;

    // One-hot handshake returns to the granted channel and the FIFO head.
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (accept)
            m_addr_ok[grant] = 1'b1;
        if (pop)
            m_data_ok[head] = 1'b1;
    end

    // Lock holds the grant across slave stalls; rr_ptr moves past each winner.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_ch    <= '0;
            rr_ptr     <= '0;
        end else begin
            if (s_req && !s_addr_ok) begin
                lock_valid <= 1'b1;
                lock_ch    <= grant;
            end else if (s_addr_ok) begin
                lock_valid <= 1'b0;
            end
            if (RR_MODE != 0 && accept)
                rr_ptr <= (grant == CW'(NUM_CH-1)) ? '0 : grant + CW'(1);
        end
    end

    // Channel-id storage; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[wr_ptr] <= grant;
    end

    // FIFO pointers, occupancy and the sticky spurious-response flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
            if (s_data_ok && count == '0)
                resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a 3-channel round-robin instance and
// a 2-channel fixed-priority instance. Expected channel ids are queued when an
// accept is driven and popped when a slave response is driven.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance signals (NUM_CH=3)
    logic [2:0]  r_req = '0, r_wr, r_aok, r_dok;
    logic [5:0]  r_size;
    logic [95:0] r_addr, r_wdata;
    logic [11:0] r_wstrb;
    logic [31:0] r_rdata, r_saddr, r_swdata, r_s_rdata = '0;
    logic        r_sreq, r_swr, r_s_aok = 1'b0, r_s_dok = 1'b0, r_err;
    logic [1:0]  r_ssize;
    logic [3:0]  r_swstrb;
    logic [2:0]  r_out;

    // Fixed-priority instance signals (NUM_CH=2)
    logic [1:0]  f_req = '0, f_wr, f_aok, f_dok;
    logic [3:0]  f_size;
    logic [63:0] f_addr, f_wdata;
    logic [7:0]  f_wstrb;
    logic [31:0] f_rdata, f_saddr, f_swdata, f_s_rdata = '0;
    logic        f_sreq, f_swr, f_s_aok = 1'b0, f_s_dok = 1'b0, f_err;
    logic [1:0]  f_ssize;
    logic [3:0]  f_swstrb;
    logic [2:0]  f_out;

    assign r_wr    = 3'b010;
    assign r_size  = {2'd2, 2'd2, 2'd2};
    assign r_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    assign r_wstrb = {4'h0, 4'hF, 4'h0};
    assign r_wdata = {32'h0, 32'hCAFE_0001, 32'h0};
    assign f_wr    = 2'b00;
    assign f_size  = {2'd2, 2'd2};
    assign f_addr  = {32'h0000_2000, 32'h0000_1000};
    assign f_wstrb = '0;
    assign f_wdata = '0;

    sram_like_arbiter #(.NUM_CH(3), .DEPTH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn),
        .m_req(r_req), .m_wr(r_wr), .m_size(r_size), .m_addr(r_addr),
        .m_wstrb(r_wstrb), .m_wdata(r_wdata),
        .m_addr_ok(r_aok), .m_data_ok(r_dok), .m_rdata(r_rdata),
        .s_req(r_sreq), .s_wr(r_swr), .s_size(r_ssize), .s_addr(r_saddr),
        .s_wstrb(r_swstrb), .s_wdata(r_swdata),
        .s_addr_ok(r_s_aok), .s_data_ok(r_s_dok), .s_rdata(r_s_rdata),
        .outstanding(r_out), .resp_err(r_err)
    );

    sram_like_arbiter #(.NUM_CH(2), .DEPTH(4), .RR_MODE(0)) u_fp (
        .clk(clk), .resetn(resetn),
        .m_req(f_req), .m_wr(f_wr), .m_size(f_size), .m_addr(f_addr),
        .m_wstrb(f_wstrb), .m_wdata(f_wdata),
        .m_addr_ok(f_aok), .m_data_ok(f_dok), .m_rdata(f_rdata),
        .s_req(f_sreq), .s_wr(f_swr), .s_size(f_ssize), .s_addr(f_saddr),
        .s_wstrb(f_swstrb), .s_wdata(f_swdata),
        .s_addr_ok(f_s_aok), .s_data_ok(f_s_dok), .s_rdata(f_s_rdata),
        .outstanding(f_out), .resp_err(f_err)
    );

    int passed = 0;
    int total  = 0;
    int rq[$];
    int fq[$];

    // Masters must hold m_req until m_addr_ok; count any drop seen at a clock edge.
    logic [2:0] r_req_q = '0, r_aok_q = '0;
    logic [1:0] f_req_q = '0, f_aok_q = '0;
    logic       rst_q = 1'b0;
    int         prot_err = 0;
    always @(posedge clk) begin
        if (resetn && rst_q &&
            (((r_req_q & ~r_aok_q & ~r_req) != 3'b0) ||
             ((f_req_q & ~f_aok_q & ~f_req) != 2'b0)))
            prot_err <= prot_err + 1;
        r_req_q <= r_req;
        r_aok_q <= r_aok;
        f_req_q <= f_req;
        f_aok_q <= f_aok;
        rst_q   <= resetn;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the RR instance; g = expected grant, -1 for no accept.
    task automatic r_drive(input logic [2:0] req, input logic aok_in, input int g,
                           input logic dok_in, input logic [31:0] rd);
        int e;
        r_req = req; r_s_aok = aok_in; r_s_dok = dok_in; r_s_rdata = rd;
        #1;
        if (g >= 0) begin
            rq.push_back(g);
            chk("rr_addr_ok", 32'(r_aok), 32'(1 << g));
            chk("rr_s_addr", r_saddr, 32'h100 * (g + 1));
        end else begin
            chk("rr_addr_ok_idle", 32'(r_aok), 32'h0);
        end
        if (dok_in && rq.size() > 0) begin
            e = rq.pop_front();
            chk("rr_data_ok", 32'(r_dok), 32'(1 << e));
            chk("rr_rdata", r_rdata, rd);
        end else begin
            chk("rr_data_ok_idle", 32'(r_dok), 32'h0);
        end
    endtask

    // Drive one cycle on the fixed-priority instance.
    task automatic f_drive(input logic [1:0] req, input logic aok_in, input int g,
                           input logic dok_in, input logic [31:0] rd);
        int e;
        f_req = req; f_s_aok = aok_in; f_s_dok = dok_in; f_s_rdata = rd;
        #1;
        if (g >= 0) begin
            fq.push_back(g);
            chk("fp_addr_ok", 32'(f_aok), 32'(1 << g));
            chk("fp_s_addr", f_saddr, 32'h1000 * (g + 1));
        end else begin
            chk("fp_addr_ok_idle", 32'(f_aok), 32'h0);
        end
        if (dok_in && fq.size() > 0) begin
            e = fq.pop_front();
            chk("fp_data_ok", 32'(f_dok), 32'(1 << e));
            chk("fp_rdata", f_rdata, rd);
        end else begin
            chk("fp_data_ok_idle", 32'(f_dok), 32'h0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rr_out", 32'(r_out), 0);
        chk("rst_rr_err", 32'(r_err), 0);
        chk("rst_rr_sreq", 32'(r_sreq), 0);
        chk("rst_rr_aok", 32'(r_aok), 0);
        chk("rst_rr_dok", 32'(r_dok), 0);
        chk("rst_fp_out", 32'(f_out), 0);
        chk("rst_fp_sreq", 32'(f_sreq), 0);
        resetn = 1'b1;
        tick();

        // Fixed priority: ch0 wins while both request, ch1 only after ch0 drops
        f_drive(2'b11, 1'b1, 0, 1'b0, 0); tick();
        f_drive(2'b11, 1'b1, 0, 1'b0, 0); tick();
        f_drive(2'b11, 1'b1, 0, 1'b0, 0); tick();
        f_drive(2'b10, 1'b1, 1, 1'b0, 0); tick();
        f_drive(2'b00, 1'b0, -1, 1'b0, 0);
        chk("fp_full_out", 32'(f_out), 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            f_drive(2'b00, 1'b0, -1, 1'b1, 32'hF0 + i); tick();
        end
        f_drive(2'b00, 1'b0, -1, 1'b0, 0);
        chk("fp_drained", 32'(f_out), 0);

        // Round-robin: grant order 0,1,2,0,1 with in-order responses
        r_drive(3'b111, 1'b1, 0, 1'b0, 0);
        chk("rr_out0", 32'(r_out), 0);
        tick();
        r_drive(3'b111, 1'b1, 1, 1'b0, 0);
        chk("rr_out1", 32'(r_out), 1);
        tick();
        r_drive(3'b111, 1'b1, 2, 1'b0, 0); tick();
        r_drive(3'b011, 1'b1, 0, 1'b1, 32'h11);
        chk("rr_out3", 32'(r_out), 3);
        tick();
        r_drive(3'b010, 1'b1, 1, 1'b1, 32'h22);
        chk("rr_out3b", 32'(r_out), 3);
        tick();
        r_drive(3'b000, 1'b0, -1, 1'b1, 32'h33); tick();

        // Concurrent push and pop at outstanding=2
        r_drive(3'b100, 1'b1, 2, 1'b1, 32'h44);
        chk("pp_out_before", 32'(r_out), 2);
        tick();
        r_drive(3'b000, 1'b0, -1, 1'b0, 0);
        chk("pp_out_after", 32'(r_out), 2);
        tick();

        // Lock: ch1 stalled four cycles while ch0 raises req
        r_drive(3'b010, 1'b0, -1, 1'b0, 0);
        chk("lock_s_addr_0", r_saddr, 32'h200);
        chk("lock_s_wr", 32'(r_swr), 1);
        chk("lock_s_wdata", r_swdata, 32'hCAFE_0001);
        chk("lock_s_wstrb", 32'(r_swstrb), 32'hF);
        tick();
        for (int i = 1; i < 4; i++) begin
            r_drive(3'b011, 1'b0, -1, 1'b0, 0);
            chk("lock_s_addr", r_saddr, 32'h200);
            chk("lock_s_req", 32'(r_sreq), 1);
            tick();
        end
        r_drive(3'b011, 1'b1, 1, 1'b0, 0); tick();
        r_drive(3'b001, 1'b1, 0, 1'b0, 0); tick();

        // Full: no request reaches the slave, not even in the popping cycle
        r_drive(3'b100, 1'b1, -1, 1'b0, 0);
        chk("full_out", 32'(r_out), 4);
        chk("full_sreq", 32'(r_sreq), 0);
        tick();
        r_drive(3'b100, 1'b1, -1, 1'b1, 32'h77);
        chk("full_pop_sreq", 32'(r_sreq), 0);
        tick();
        r_drive(3'b100, 1'b1, 2, 1'b0, 0);
        chk("after_pop_sreq", 32'(r_sreq), 1);
        chk("after_pop_out", 32'(r_out), 3);
        tick();
        r_drive(3'b000, 1'b0, -1, 1'b0, 0);
        chk("refill_out", 32'(r_out), 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            r_drive(3'b000, 1'b0, -1, 1'b1, 32'h81 + i); tick();
        end

        // Spurious response with an empty FIFO
        r_drive(3'b000, 1'b0, -1, 1'b1, 32'h99);
        chk("spur_out", 32'(r_out), 0);
        tick();
        r_drive(3'b000, 1'b0, -1, 1'b0, 0);
        chk("spur_err", 32'(r_err), 1);
        tick();
        chk("spur_err_sticky", 32'(r_err), 1);

        // Asynchronous reset mid-burst at outstanding=3
        r_drive(3'b111, 1'b1, 0, 1'b0, 0); tick();
        r_drive(3'b110, 1'b1, 1, 1'b0, 0); tick();
        r_drive(3'b100, 1'b1, 2, 1'b0, 0); tick();
        r_drive(3'b000, 1'b0, -1, 1'b0, 0);
        chk("burst_out", 32'(r_out), 3);
        resetn = 1'b0;
        r_s_dok = 1'b1;
        #1;
        chk("arst_out", 32'(r_out), 0);
        chk("arst_err", 32'(r_err), 0);
        chk("arst_dok", 32'(r_dok), 0);
        rq.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        r_s_dok = 1'b0;
        tick();
        r_drive(3'b001, 1'b0, -1, 1'b0, 0);
        chk("post_rst_sreq", 32'(r_sreq), 1);
        tick();
        r_drive(3'b001, 1'b1, 0, 1'b0, 0); tick();
        r_drive(3'b000, 1'b0, -1, 1'b1, 32'h5A); tick();
        chk("post_rst_out", 32'(r_out), 0);

        chk("protocol", 32'(prot_err), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
